// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter/sequencer sharing one 32-bit carry-lookahead adder
// among NREQ requesters. Results return on a valid/ready channel tagged with the
// requester index.
// Optional feature macro: ADDARB_LOCK_EN (sticky pointer for multi-word chained adds).
module add_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   a_flat,
    input  logic [32*NREQ-1:0]   b_flat,
    input  logic [NREQ-1:0]      cin,
    input  logic [NREQ-1:0]      lock,
    output logic [NREQ-1:0]      gnt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_of
);

    typedef enum logic [1:0] {StIdle, StAdd, StResp} state_t;

    state_t          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  op_id_q;
    logic [31:0]     op_a_q;
    logic [31:0]     op_b_q;
    logic            op_cin_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [31:0]     rsp_sum_q;
    logic            rsp_cout_q;
    logic            rsp_of_q;

    logic [31:0]     a_arr [NREQ];
    logic [31:0]     b_arr [NREQ];

    logic            arb_en;
    logic [IDW-1:0]  ptr_next;
    logic [IDW-1:0]  base;
    logic [IDW-1:0]  idx;
    logic [IDW-1:0]  win;
    logic            found;
    logic [31:0]     a_sel;
    logic [31:0]     b_sel;
    logic            cin_sel;

    logic [31:0]     g;
    logic [31:0]     p;
    logic [32:0]     c;
    logic            grp_g;
    logic            grp_p;
    logic [31:0]     add_sum;
    logic            add_cout;
    logic            add_of;

`ifdef ADDARB_LOCK_EN
    logic            op_lock_q;
    logic            lock_sel;
    assign lock_sel = lock[win];
`else
    logic            unused_lock;
    assign unused_lock = ^lock;
`endif

    // Unpack the flat operand buses into per-requester words.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = a_flat[32*i +: 32];
        assign b_arr[i] = b_flat[32*i +: 32];
    end

    // Arbitration is open when idle, or in RESP on the handshake cycle.
    assign arb_en = (state_q == StIdle) || ((state_q == StResp) && rsp_ready);

    // Pointer value taken on the response handshake; a locked owner keeps priority.
    always_comb begin
        if (rsp_id_q == IDW'(NREQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = rsp_id_q + 1'b1;
        end
`ifdef ADDARB_LOCK_EN
        if (op_lock_q) begin
            ptr_next = rsp_id_q;
        end
`endif
    end

    // In RESP the search starts from the pointer as it will be after the handshake.
    assign base = (state_q == StResp) ? ptr_next : ptr_q;

    // First requesting index at or after base, wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        idx     = '0;
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(base) + k) % NREQ);
            if (!found && req[idx]) begin
                found   = 1'b1;
                win     = idx;
                a_sel   = a_arr[idx];
                b_sel   = b_arr[idx];
                cin_sel = cin[idx];
            end
        end
    end

    // One-hot grant, only in the capture cycle.
    always_comb begin
        gnt = '0;
        if (arb_en && found) begin
            gnt[win] = 1'b1;
        end
    end

    // Carry-lookahead adder: 4-bit lookahead groups, group carries chained.
    always_comb begin
        g     = op_a_q & op_b_q;
        p     = op_a_q ^ op_b_q;
        c     = '0;
        grp_g = 1'b0;
        grp_p = 1'b0;
        c[0]  = op_cin_q;
        for (int j = 0; j < 8; j++) begin
            c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            grp_g    = g[4*j+3] | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_p    = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
            c[4*j+4] = grp_g | (grp_p & c[4*j]);
        end
        add_sum  = p ^ c[31:0];
        add_cout = c[32];
        add_of   = (op_a_q[31] == op_b_q[31]) && (add_sum[31] != op_a_q[31]);
    end

    // Sequencer: capture on grant, register adder result, hold until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            op_id_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_of_q    <= 1'b0;
`ifdef ADDARB_LOCK_EN
            op_lock_q   <= 1'b0;
`endif
        end else begin
            if (arb_en && found) begin
                op_a_q   <= a_sel;
                op_b_q   <= b_sel;
                op_cin_q <= cin_sel;
                op_id_q  <= win;
`ifdef ADDARB_LOCK_EN
                op_lock_q <= lock_sel;
`endif
            end
            case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    rsp_sum_q   <= add_sum;
                    rsp_cout_q  <= add_cout;
                    rsp_of_q    <= add_of;
                    rsp_id_q    <= op_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= ptr_next;
                        state_q     <= found ? StAdd : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_of    = rsp_of_q;

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed self-checking bench for add_arbiter with a response scoreboard.
module tb_add_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    sum;
        logic           cout;
        logic           of;
    } exp_t;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [32*NREQ-1:0]  a_flat;
    logic [32*NREQ-1:0]  b_flat;
    logic [NREQ-1:0]     cin;
    logic [NREQ-1:0]     lock;
    logic [NREQ-1:0]     gnt;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_sum;
    logic                rsp_cout;
    logic                rsp_of;

    exp_t q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .cin       (cin),
        .lock      (lock),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_of    (rsp_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int id, input logic [31:0] a, input logic [31:0] b,
                                input logic ci);
        exp_t r;
        logic [32:0] s;
        s      = {1'b0, a} + {1'b0, b} + {32'b0, ci};
        r.id   = IDW'(id);
        r.sum  = s[31:0];
        r.cout = s[32];
        r.of   = (a[31] == b[31]) && (s[31] != a[31]);
        return r;
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic ci);
        a_flat[32*i +: 32] = a;
        b_flat[32*i +: 32] = b;
        cin[i]             = ci;
    endtask

    task automatic push_op(input int i);
        q.push_back(mk(i, a_flat[32*i +: 32], b_flat[32*i +: 32], cin[i]));
    endtask

    task automatic check_rsp();
        exp_t e;
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        if (q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e    = q.pop_front();
            last = e;
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
            chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
            chk("rsp_of", 64'(rsp_of), 64'(e.of));
        end
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    endtask

    initial begin
        int exp_rr [5];
        int exp_lk [4];
        exp_rr = '{0, 1, 2, 3, 0};
        exp_lk = '{0, 1, 1, 0};
        rst = 1'b1; req = '0; a_flat = '0; b_flat = '0; cin = '0; lock = '0;
        rsp_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_valid", 64'(rsp_valid), 64'd0);
        chk("reset_id", 64'(rsp_id), 64'd0);
        chk("reset_sum", 64'(rsp_sum), 64'd0);
        chk("reset_cout_of", 64'({rsp_cout, rsp_of}), 64'd0);

        // Single request: signed overflow.
        set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        req = 4'b0001; #1;
        chk("t1_gnt", 64'(gnt), 64'h1);
        push_op(0);
        tick(); req = '0; #1;
        chk("t1_gnt_add", 64'(gnt), 64'd0);
        chk("t1_no_valid_add", 64'(rsp_valid), 64'd0);
        tick();
        check_rsp();
        tick();
        chk("t1_valid_drop", 64'(rsp_valid), 64'd0);

        // Carry-out; pointer now at 1, search wraps to 0.
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        req = 4'b0001; #1;
        chk("t2_gnt", 64'(gnt), 64'h1);
        push_op(0);
        tick(); req = '0;
        wait_rsp();
        check_rsp();
        tick();

        // Reset in ADD: response dropped, pointer cleared.
        set_op(2, 32'h1234_5678, 32'h1111_1111, 1'b0);
        req = 4'b0100; #1;
        chk("t5_gnt", 64'(gnt), 64'h4);
        tick();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0; #1;
        chk("t5_valid", 64'(rsp_valid), 64'd0);
        chk("t5_sum", 64'(rsp_sum), 64'd0);
        chk("t5_id", 64'(rsp_id), 64'd0);
        chk("t5_gnt_idle", 64'(gnt), 64'd0);
        tick();
        chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
        set_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        set_op(3, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
        req = 4'b1001; #1;
        chk("t5_gnt_from0", 64'(gnt), 64'h1);
        push_op(0);
        tick(); req = '0;
        wait_rsp();
        check_rsp();
        tick();

        // Round-robin with all requesting, back-to-back.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op(i, 32'h9000_0000 + 32'(i) * 32'h1111, 32'hF000_0001 ^ 32'(i), i[0]);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(1) << exp_rr[k]);
            push_op(exp_rr[k]);
            tick();
            chk($sformatf("rr_gap%0d", k), 64'(gnt), 64'd0);
            tick();
            check_rsp();
        end
        req = '0;
        tick();

        // Backpressure: second requester waits for the handshake.
        set_op(1, 32'hAAAA_AAAA, 32'h5555_5556, 1'b0);
        set_op(2, 32'h8000_0000, 32'h8000_0000, 1'b1);
        req = 4'b0010; #1;
        chk("bp_gnt1", 64'(gnt), 64'h2);
        push_op(1);
        tick();
        req = 4'b0100; rsp_ready = 1'b0;
        tick();
        check_rsp();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_gnt0_%0d", k), 64'(gnt), 64'd0);
            tick();
            chk($sformatf("bp_valid_%0d", k), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp_hold_%0d", k),
                64'({rsp_id, rsp_sum, rsp_cout, rsp_of}), 64'(last));
        end
        rsp_ready = 1'b1; #1;
        chk("bp_gnt2", 64'(gnt), 64'h4);
        push_op(2);
        tick(); req = '0;
        wait_rsp();
        check_rsp();
        tick();

`ifdef ADDARB_LOCK_EN
        // Lock: requester 1 keeps priority for one extra operation.
        rst = 1'b1; tick(); rst = 1'b0;
        set_op(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            lock = (k == 1) ? 4'b0010 : 4'b0000;
            #1;
            chk($sformatf("lk_gnt%0d", k), 64'(gnt), 64'(1) << exp_lk[k]);
            push_op(exp_lk[k]);
            tick();
            tick();
            check_rsp();
        end
        req = '0; lock = '0;
        tick();
`else
        exp_lk[0] = exp_lk[1];
`endif

        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter and sequencer that shares one 32-bit carry-lookahead adder (`CLA32bit`) among `NREQ` requesters. Each requester presents two operands and a carry-in. The block grants one requester at a time and registers its operands into the adder. It returns the registered sum, carry-out and signed overflow on a valid/ready response channel tagged with the requester index. It sits between the ALU-side clients and the shared adder datapath.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default 2: requester-index width; must equal `$clog2(NREQ)`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request; held until granted.
- `a_flat`  in  32*NREQ  operand A; requester i occupies bits [32i+31:32i].
- `b_flat`  in  32*NREQ  operand B; same packing as `a_flat`.
- `cin`  in  NREQ  per-requester carry-in.
- `lock`  in  NREQ  per-requester lock request; used only under `ADDARB_LOCK_EN`.
- `gnt`  out  NREQ  one-hot grant, combinational; high in the capture cycle only.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_sum`  out  32  registered sum.
- `rsp_cout`  out  1  registered carry-out.
- `rsp_of`  out  1  registered signed overflow.

## Operation
- States:
  - IDLE: no operation in flight.
  - ADD: operand registers hold the granted operation; the adder is evaluating.
  - RESP: result registered, `rsp_valid` high.
- IDLE:
  - If `req` != 0, grant the first requesting index at or after `ptr`, searching upward and wrapping modulo NREQ.
  - In that cycle: assert `gnt[i]`; capture A, B, `cin` and `i` into operand registers; go to ADD.
  - If `req` == 0, remain in IDLE; `gnt` = 0.
- ADD:
  - Latch the adder's sum, cout and of into the `rsp_*` registers.
  - Set `rsp_valid` = 1 and `rsp_id` = captured index; go to RESP.
  - `gnt` = 0 in this state.
- RESP:
  - Hold all `rsp_*` outputs stable while `rsp_ready` = 0.
  - On `rsp_valid && rsp_ready`: set `ptr` = (`rsp_id` + 1) mod NREQ.
  - On the same handshake, if `req` != 0, grant the next winner in the same cycle, searching from the updated `ptr`; go to ADD. Otherwise go to IDLE.
  - `gnt` is asserted in RESP only on a handshake cycle.
- Fairness: a requester that is continuously requesting is granted within NREQ operations.
- Arithmetic: sum = A + B + cin mod 2^32.
- cout: carry out of bit 31.
- of: (A[31] == B[31]) && (sum[31] != A[31]).
- Requester contract: `req` and operands stay stable until a cycle with `gnt[i]` high. A requester may deassert `req` in the cycle after its grant.
- A `req` that drops before it is granted is ignored, with no side effect.
- Reset: on any cycle with `rst` = 1, go to IDLE and clear `ptr` to 0. An in-flight operation is dropped without a response.
- Reset values: `gnt` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_of` = 0.

## Timing
- Latency: grant at edge k; `rsp_valid` is high from edge k+1.
- Throughput: one operation per 2 cycles when `rsp_ready` is held high and requests are pending.
- Backpressure: none is lost. The block stalls in RESP, and `gnt` stays 0 until the handshake.
- `gnt` is combinational from state, `req`, `ptr` and `rsp_ready`. There is no combinational path from `rsp_ready` to `rsp_*`.
- The adder path is one full cycle, from operand registers to `rsp_*` registers.

## Configuration
- Macro: `ADDARB_LOCK_EN`.
- Defined:
  - If `lock[i]` is high when requester i is granted, `ptr` stays at i on the response handshake instead of advancing.
  - Requester i therefore wins the next arbitration if it is still requesting. This supports multi-word adds that chain through the requester's own carry.
  - The lock is released when i is granted with `lock[i]` = 0, or when `req[i]` is low at arbitration.
- Undefined: the `lock` port is present but ignored, and pure round-robin applies.

## Test plan
- Single request, no backpressure:
  - Stimulus: `req` = 0001, A = 0x7FFF_FFFF, B = 0x0000_0001, cin = 0.
  - Required: `gnt` = 0001 at edge 0; `rsp_valid` at edge 1 with sum = 0x8000_0000, cout = 0, of = 1, id = 0.
- Carry-out:
  - Stimulus: A = 0xFFFF_FFFF, B = 0x0000_0000, cin = 1.
  - Required: sum = 0, cout = 1, of = 0.
- Round-robin:
  - Stimulus: `req` = 1111 held, `rsp_ready` = 1.
  - Required: grant order 0, 1, 2, 3, 0, with a grant every 2 cycles.
- Backpressure:
  - Stimulus: `rsp_ready` = 0 for 5 cycles after a response, with a second `req` pending.
  - Required: `rsp_*` stable and `gnt` = 0 throughout; second grant in the cycle `rsp_ready` rises.
- Reset mid-operation:
  - Stimulus: `rst` = 1 in the ADD state.
  - Required: no response; outputs at reset values; next grant searches from index 0.
- Lock (with `ADDARB_LOCK_EN`):
  - Stimulus: `req` = 0011 with `lock[1]` = 1 on the first operation of requester 1.
  - Required: grant order 0, 1, 1, 0.
